// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture/playback blocks: default word
// width, receiver FSM state encoding and I2S channel encoding.
package audio_pkg;

  // Default number of bits captured per channel word.
  localparam int AUDIO_DATA_W = 16;

  // I2S receiver frame-alignment states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } rx_state_t;

  // LRCLK level encodes the channel: low = left, high = right.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_t;

  // Width of a counter that must hold the values 0..max_count.
  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Brings an asynchronous pin into the sample_clk domain through two flops,
// then keeps one more registered copy so rising and falling edges can be
// reported as single-cycle strobes alongside the synchronized level.
module sync_edge (
  input  logic sample_clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchronizer followed by the edge-detect history flop.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S capture from the WM8731 ADC with the codec as clock master.
// The bit clock, word clock and data pins are oversampled in sample_clk,
// words are aligned to LRCLK edges and complete left/right pairs are
// offered one frame at a time over a valid/ready handshake.
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic              sample_clk,
  input  logic              rst,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_adcdat,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              overrun,
  output logic              short_err,
  input  logic              err_clr
);

  localparam int CNT_W = count_width(DATA_W);

  logic bclk_rise;
  logic bclk_fall;
  logic bclk_level;
  logic lr_rise;
  logic lr_fall;
  logic lr_level;
  logic lr_edge;
  logic unused_bclk;

  logic dat_meta;
  logic dat_sync;
  logic dat_dly;

  rx_state_t   state;
  rx_state_t   state_next;
  channel_t    channel;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] left_stage;
  logic              left_staged;

  logic shift_en;
  logic word_done;
  logic chan_load;
  logic short_hit;
  logic commit;
  logic commit_load;
  logic accept;

  sync_edge u_bclk_sync (
    .sample_clk (sample_clk),
    .rst        (rst),
    .din        (i2s_bclk),
    .level      (bclk_level),
    .rise       (bclk_rise),
    .fall       (bclk_fall)
  );

  sync_edge u_lrclk_sync (
    .sample_clk (sample_clk),
    .rst        (rst),
    .din        (i2s_lrclk),
    .level      (lr_level),
    .rise       (lr_rise),
    .fall       (lr_fall)
  );

  assign lr_edge     = lr_rise | lr_fall;
  assign unused_bclk = bclk_fall ^ bclk_level;

  // ADCDAT synchronizer plus one delay flop so it lines up with the BCLK strobe.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      dat_meta <= 1'b0;
      dat_sync <= 1'b0;
      dat_dly  <= 1'b0;
    end else begin
      dat_meta <= i2s_adcdat;
      dat_sync <= dat_meta;
      dat_dly  <= dat_sync;
    end
  end

  assign shift_next = {shift_reg[DATA_W-2:0], dat_dly};

  // Frame-alignment state register.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle capture controls; LRCLK edges take priority over bit strobes.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    word_done  = 1'b0;
    chan_load  = 1'b0;
    short_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lr_fall) begin
          chan_load  = 1'b1;
          state_next = SKIP;
        end
      end
      SKIP: begin
        if (lr_edge) begin
          chan_load = 1'b1;
        end else if (bclk_rise) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (lr_edge) begin
          short_hit  = 1'b1;
          chan_load  = 1'b1;
          state_next = SKIP;
        end else if (bclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            word_done  = 1'b1;
            state_next = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (lr_edge) begin
          chan_load  = 1'b1;
          state_next = SKIP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Channel follows the LRCLK level captured at each accepted word-clock edge.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      channel <= LEFT;
    end else if (chan_load) begin
      channel <= channel_t'(lr_level);
    end
  end

  // Bit counter and shift register only live while in SHIFT, so partial words vanish.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state != SHIFT) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      bit_cnt   <= bit_cnt + CNT_W'(1);
      shift_reg <= shift_next;
    end
  end

  // Left staging: a new left slot or a short word invalidates it, a right word consumes it.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      left_stage  <= '0;
      left_staged <= 1'b0;
    end else if (chan_load && (lr_level == LEFT)) begin
      left_staged <= 1'b0;
    end else if (short_hit) begin
      left_staged <= 1'b0;
    end else if (word_done) begin
      if (channel == LEFT) begin
        left_stage  <= shift_next;
        left_staged <= 1'b1;
      end else begin
        left_staged <= 1'b0;
      end
    end
  end

  assign commit      = word_done && (channel == RIGHT) && left_staged;
  assign accept      = frame_valid && frame_ready;
  assign commit_load = commit && (!frame_valid || frame_ready);

  // Presented frame: load on commit when the slot is free or being accepted, else drop on accept.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      left_data   <= '0;
      right_data  <= '0;
      frame_valid <= 1'b0;
    end else if (commit_load) begin
      left_data   <= left_stage;
      right_data  <= shift_next;
      frame_valid <= 1'b1;
    end else if (accept) begin
      frame_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      short_err <= 1'b0;
    end else begin
      if (commit && frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (short_hit) begin
        short_err <= 1'b1;
      end else if (err_clr) begin
        short_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives an I2S codec model with BCLK at
// sample_clk/8 and 32-bit slots, then checks presented frames, handshake
// behaviour and the sticky error flags.
module tb_i2s_receiver;

  logic        sample_clk;
  logic        rst;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_adcdat;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        short_err;
  logic        err_clr;

  int total_checks;
  int bad_checks;
  int accept_count;
  int valid_cycles;
  logic [15:0] last_left;
  logic [15:0] last_right;

  typedef struct {
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[4];

  i2s_receiver #(.DATA_W(16)) dut (
    .sample_clk  (sample_clk),
    .rst         (rst),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_adcdat  (i2s_adcdat),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .short_err   (short_err),
    .err_clr     (err_clr)
  );

  initial sample_clk = 1'b0;
  always #5 sample_clk = ~sample_clk;

  // Consumer-side observer: counts valid cycles and records every accepted frame.
  always @(negedge sample_clk) begin
    if (frame_valid) valid_cycles++;
    if (frame_valid && frame_ready) begin
      accept_count++;
      last_left  = left_data;
      last_right = right_data;
    end
  end

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One LRCLK slot of nbits bit periods; MSB follows the one-bit I2S delay.
  // With pulse set, frame_ready is raised for exactly the commit cycle of bit 16.
  task automatic sendSlot(input logic ch, input logic [15:0] word, input int nbits,
                          input logic pulse);
    for (int i = 0; i < nbits; i++) begin
      i2s_bclk   = 1'b0;
      i2s_lrclk  = ch;
      i2s_adcdat = (i >= 1 && i <= 16) ? word[16 - i] : 1'b0;
      repeat (4) tick();
      i2s_bclk = 1'b1;
      if (pulse && i == 16) begin
        tick();
        tick();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        tick();
      end else begin
        repeat (4) tick();
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] left, input logic [15:0] right,
                               input logic pulse);
    sendSlot(1'b0, left, 32, 1'b0);
    sendSlot(1'b1, right, 32, pulse);
  endtask

  initial begin
    int acc0;
    int pul0;

    total_checks = 0;
    bad_checks   = 0;
    accept_count = 0;
    valid_cycles = 0;
    last_left    = '0;
    last_right   = '0;

    vecs[0] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1};
    vecs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1};
    vecs[3] = '{16'hA5C3, 16'h5A3C, 16'hA5C3, 16'h5A3C, 1};

    rst         = 1'b1;
    i2s_bclk    = 1'b0;
    i2s_lrclk   = 1'b1;
    i2s_adcdat  = 1'b0;
    frame_ready = 1'b1;
    err_clr     = 1'b0;
    repeat (3) tick();

    checkOutput("reset_left", left_data, 16'h0000);
    checkOutput("reset_right", right_data, 16'h0000);
    checkOutput("reset_valid", frame_valid, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_short", short_err, 1'b0);

    rst = 1'b0;
    tick();
    sendSlot(1'b1, 16'h1234, 32, 1'b0);
    checkOutput("lone_right_no_accept", accept_count, 0);

    $display("[TB] nominal frames, ready held high");
    for (int v = 0; v < 4; v++) begin
      acc0 = accept_count;
      pul0 = valid_cycles;
      applyStimulus(vecs[v].in_left, vecs[v].in_right, 1'b0);
      checkOutput($sformatf("nom%0d_left", v), last_left, vecs[v].exp_left);
      checkOutput($sformatf("nom%0d_right", v), last_right, vecs[v].exp_right);
      checkOutput($sformatf("nom%0d_pulses", v), valid_cycles - pul0, vecs[v].exp_pulses);
      checkOutput($sformatf("nom%0d_accepts", v), accept_count - acc0, 1);
      checkOutput($sformatf("nom%0d_overrun", v), overrun, 1'b0);
      checkOutput($sformatf("nom%0d_short", v), short_err, 1'b0);
    end

    $display("[TB] backpressure and overrun");
    frame_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    checkOutput("bp_first_valid", frame_valid, 1'b1);
    checkOutput("bp_first_overrun", overrun, 1'b0);
    applyStimulus(16'h3333, 16'h4444, 1'b0);
    checkOutput("bp_hold_left", left_data, 16'h1111);
    checkOutput("bp_hold_right", right_data, 16'h2222);
    checkOutput("bp_valid", frame_valid, 1'b1);
    checkOutput("bp_overrun", overrun, 1'b1);
    frame_ready = 1'b1;
    tick();
    tick();
    checkOutput("bp_valid_drop", frame_valid, 1'b0);
    checkOutput("bp_accepted_left", last_left, 16'h1111);
    checkOutput("bp_overrun_sticky", overrun, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("bp_overrun_clr", overrun, 1'b0);

    $display("[TB] short left word");
    acc0 = accept_count;
    sendSlot(1'b0, 16'hDEAD, 11, 1'b0);
    sendSlot(1'b1, 16'hBEEF, 32, 1'b0);
    checkOutput("short_flag", short_err, 1'b1);
    checkOutput("short_no_frame", accept_count - acc0, 0);
    applyStimulus(16'hAAAA, 16'h5555, 1'b0);
    checkOutput("short_next_accepts", accept_count - acc0, 1);
    checkOutput("short_next_left", last_left, 16'hAAAA);
    checkOutput("short_next_right", last_right, 16'h5555);
    checkOutput("short_sticky", short_err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("short_clr", short_err, 1'b0);

    $display("[TB] accept and commit in the same cycle");
    frame_ready = 1'b0;
    applyStimulus(16'hC3C3, 16'h3C3C, 1'b0);
    checkOutput("same_first_left", left_data, 16'hC3C3);
    checkOutput("same_first_valid", frame_valid, 1'b1);
    applyStimulus(16'h1E1E, 16'hE1E1, 1'b1);
    checkOutput("same_left", left_data, 16'h1E1E);
    checkOutput("same_right", right_data, 16'hE1E1);
    checkOutput("same_valid", frame_valid, 1'b1);
    checkOutput("same_overrun", overrun, 1'b0);
    checkOutput("same_accepted_old", last_left, 16'hC3C3);

    $display("[TB] reset during the right word");
    sendSlot(1'b0, 16'h1357, 32, 1'b0);
    sendSlot(1'b1, 16'h9999, 10, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_left", left_data, 16'h0000);
    checkOutput("rstmid_right", right_data, 16'h0000);
    checkOutput("rstmid_valid", frame_valid, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    frame_ready = 1'b1;
    acc0 = accept_count;
    sendSlot(1'b1, 16'h9999, 22, 1'b0);
    checkOutput("rstmid_no_partial", accept_count - acc0, 0);
    applyStimulus(16'h2468, 16'h9BDF, 1'b0);
    checkOutput("rstmid_accepts", accept_count - acc0, 1);
    checkOutput("rstmid_left_after", last_left, 16'h2468);
    checkOutput("rstmid_right_after", last_right, 16'h9BDF);

    $display("[TB] reset released mid right word");
    rst = 1'b1;
    sendSlot(1'b1, 16'h1234, 8, 1'b0);
    rst = 1'b0;
    acc0 = accept_count;
    sendSlot(1'b1, 16'h1234, 24, 1'b0);
    checkOutput("midstart_valid", frame_valid, 1'b0);
    checkOutput("midstart_none", accept_count - acc0, 0);
    applyStimulus(16'h0F0F, 16'hF0F0, 1'b0);
    checkOutput("midstart_accepts", accept_count - acc0, 1);
    checkOutput("midstart_left", last_left, 16'h0F0F);
    checkOutput("midstart_right", last_right, 16'hF0F0);
    checkOutput("midstart_short", short_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
